alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one pipelined 64-bit ALU (ALU64bit) among NREQ requesters using round-robin arbitration.
- Issues at most one operation per cycle and carries each requester's id alongside the ALU latency.
- Returns result, carry and overflow to the issuing requester with a one-cycle done pulse.
- Sits between the core's execution units and the single ALU instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must equal ceil(log2(NREQ)).
- LAT, 2, ALU latency in cycles from inputs driven to Z valid. Fixed by the ALU's input and output registers.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request. Held high until the matching gnt bit.
- req_a  in  NREQ*64  operand A; requester i uses bits [64i+63:64i].
- req_b  in  NREQ*64  operand B, same packing as req_a.
- req_op  in  NREQ*4  ALU opcode; requester i uses bits [4i+3:4i].
- gnt  out  NREQ  one-hot grant, combinational, valid in the issue cycle.
- alu_a  out  64  to ALU A.
- alu_b  out  64  to ALU B.
- alu_op  out  4  to ALU opcode.
- alu_z  in  64  from ALU Z.
- alu_carry  in  1  from ALU carry.
- alu_ovf  in  1  from ALU overflow.
- done  out  NREQ  one-hot, registered, one-cycle completion pulse.
- done_id  out  IDW  id of the completing requester; 0 when idle.
- res_z  out  64  result. Combinational pass-through of alu_z, qualified by done.
- res_carry  out  1  pass-through of alu_carry.
- res_ovf  out  1  pass-through of alu_ovf.

Behaviour:
- State:
  - Round-robin pointer ptr[IDW-1:0].
  - Tag pipeline of LAT stages, each holding {valid, id}.
- Arbitration (combinational):
  - Scan req from index ptr upward, wrapping modulo NREQ.
  - The first set bit wins; gnt has exactly that bit set.
  - gnt = 0 when req = 0.
- Issue cycle T (gnt nonzero):
  - alu_a, alu_b, alu_op are muxed from the winner.
  - At the clock edge ending T, ptr <= winner+1 mod NREQ, and stage0 <= {1, winner}.
- Idle cycle:
  - alu_a = alu_b = 0, alu_op = 4'b0000.
  - stage0 <= {0, 0}; ptr unchanged.
- Pipeline:
  - stage k+1 <= stage k on every clock edge. There is no stall; the ALU accepts every cycle.
- Completion:
  - done is driven from the last stage, so done[id] = 1 in cycle T+LAT, exactly when alu_z holds that op's result.
  - done_id = id in that cycle.
- Throughput and ordering:
  - One issue per cycle.
  - A requester holding req continuously is granted every cycle when it is the only requester, so multiple ops per requester may be in flight.
  - Results complete in issue order.
- Fairness: with all NREQ requesting, grants rotate 0,1,..,NREQ-1,0,... Maximum wait is NREQ-1 cycles.
- A requester may change req_a, req_b and req_op only after its gnt cycle.
- Simultaneous events: a done pulse and a new grant to the same requester in the same cycle are independent and both occur.
- Reset:
  - Asynchronous. ptr = 0, all stages {0, 0}, done = 0, done_id = 0.
  - gnt follows req combinationally even during reset. Requesters must ignore gnt while rst = 1.
  - In-flight ops at reset are discarded and never produce done. The ALU shares rst.
- Width rules:
  - The arbiter never modifies data; all arithmetic is in the ALU.
  - ptr wrap uses modulo NREQ. NREQ need not be a power of two.

Test Plan:
1. Single add: req=0001, A=5, B=3, op=1000 at cycle T -> gnt=0001 in T; done=0001 at T+2, res_z=8, res_carry=0, res_ovf=0.
2. Full contention: req=1111 held, each requester i issuing op=1000, A=i, B=10, dropping req after its grant -> gnt 0001,0010,0100,1000 in T..T+3; done in the same order at T+2..T+5, res_z=10,11,12,13.
3. Round robin: after a grant to requester 2, req=1001 -> requester 3 granted first, then 0 the next cycle; ptr ends at 1.
4. Subtract overflow: A=0x8000_0000_0000_0000, B=1, op=1001 -> res_z=0x7FFF_FFFF_FFFF_FFFF, res_carry=1, res_ovf=1 at T+2.
5. Compare: A=0xFFFF_FFFF_FFFF_FFFF, B=0, op=1010 from requester 1 -> done=0010, done_id=1, res_z=1.
6. Reset mid-flight: issue at T, rst pulsed during T+1 -> no done at T+2; next request after reset is granted with ptr=0 priority.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one pipelined 64-bit ALU.
// Requester ids ride a tag pipeline matching the ALU latency.
module alu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*64-1:0] req_b,
  input  logic [NREQ*4-1:0]  req_op,
  output logic [NREQ-1:0]    gnt,
  output logic [63:0]        alu_a,
  output logic [63:0]        alu_b,
  output logic [3:0]         alu_op,
  input  logic [63:0]        alu_z,
  input  logic               alu_carry,
  input  logic               alu_ovf,
  output logic [NREQ-1:0]    done,
  output logic [IDW-1:0]     done_id,
  output logic [63:0]        res_z,
  output logic               res_carry,
  output logic               res_ovf
);

  if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || LAT < 1)
  begin : g_param_chk
    $error("alu_rr_arbiter: inconsistent parameters");
  end

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  tag_t           tag_in;
  tag_t           tag_q [LAT];
  tag_t           tag_out;

  // Scan requests starting at ptr, wrapping modulo NREQ.
  always_comb begin
    gnt   = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) gnt[win] = 1'b1;
  end

  // Pointer moves past the winner; NREQ need not be a power of two.
  always_comb begin
    ptr_nxt = ptr;
    if (found) begin
      if (win == IDW'(NREQ - 1)) ptr_nxt = '0;
      else                       ptr_nxt = win + IDW'(1);
    end
  end

  // Route the winner's operands; drive zeros when nobody issues.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (found) begin
      alu_a  = req_a[{win, 6'd0} +: 64];
      alu_b  = req_b[{win, 6'd0} +: 64];
      alu_op = req_op[{win, 2'd0} +: 4];
    end
  end

  // Tag entering the pipeline this cycle.
  always_comb begin
    tag_in = '0;
    if (found) begin
      tag_in.vld = 1'b1;
      tag_in.id  = win;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

  // Tag shift register; never stalls since the ALU takes one op per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_out = tag_q[LAT-1];

  // Completion decoded from the last tag stage, aligned with alu_z.
  always_comb begin
    done    = '0;
    done_id = '0;
    if (tag_out.vld) begin
      done[tag_out.id] = 1'b1;
      done_id          = tag_out.id;
    end
  end

  // Result pass-through; Z is zeroed outside completion cycles.
  always_comb begin
    res_z     = (|done) ? alu_z : '0;
    res_carry = alu_carry;
    res_ovf   = alu_ovf;
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed scoreboard bench for alu_rr_arbiter.
// Includes a two-register ALU model standing in for ALU64bit.
module tb_alu_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 2;

  localparam logic [3:0] ADD = 4'b1000;
  localparam logic [3:0] SUB = 4'b1001;
  localparam logic [3:0] CMP = 4'b1010;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic [NREQ*4-1:0]  req_op;
  logic [NREQ-1:0]    gnt;
  logic [63:0]        alu_a;
  logic [63:0]        alu_b;
  logic [3:0]         alu_op;
  logic [63:0]        alu_z;
  logic               alu_carry;
  logic               alu_ovf;
  logic [NREQ-1:0]    done;
  logic [IDW-1:0]     done_id;
  logic [63:0]        res_z;
  logic               res_carry;
  logic               res_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          id;
    logic [63:0] z;
    logic        c;
    logic        o;
    int          at;
  } exp_t;

  exp_t sb[$];

  alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .done(done), .done_id(done_id),
    .res_z(res_z), .res_carry(res_carry), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [65:0] alu_f(logic [63:0] a, logic [63:0] b,
                                        logic [3:0] op);
    logic [64:0] s;
    logic [63:0] z;
    logic        c;
    logic        o;
    z = '0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      ADD: begin
        s = {1'b0, a} + {1'b0, b};
        z = s[63:0];
        c = s[64];
        o = (a[63] == b[63]) && (z[63] != a[63]);
      end
      SUB: begin
        z = a - b;
        c = (a >= b);
        o = (a[63] != b[63]) && (z[63] != a[63]);
      end
      CMP: z = {63'd0, $signed(a) < $signed(b)};
      default: ;
    endcase
    return {c, o, z};
  endfunction

  logic [63:0] a1, b1;
  logic [3:0]  op1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a1 <= '0; b1 <= '0; op1 <= '0;
      alu_z <= '0; alu_carry <= 1'b0; alu_ovf <= 1'b0;
    end else begin
      a1 <= alu_a; b1 <= alu_b; op1 <= alu_op;
      {alu_carry, alu_ovf, alu_z} <= alu_f(a1, b1, op1);
    end
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%b required=none", done);
      end else begin
        e = sb.pop_front();
        chk("done_onehot", 64'(done), 64'(1) << e.id);
        chk("done_id", 64'(done_id), 64'(e.id));
        chk("done_cycle", 64'(cyc), 64'(e.at));
        chk("res_z", res_z, e.z);
        chk("res_carry", 64'(res_carry), 64'(e.c));
        chk("res_ovf", 64'(res_ovf), 64'(e.o));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int i, logic [63:0] a, logic [63:0] b,
                        logic [3:0] op);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
    req_op[i*4 +: 4]  = op;
  endtask

  task automatic issue(logic [3:0] r, logic [3:0] eg, string n);
    req = r;
    #1;
    chk(n, 64'(gnt), 64'(eg));
  endtask

  task automatic expect_res(int id, logic [63:0] z, logic c, logic o);
    sb.push_back('{id: id, z: z, c: c, o: o, at: cyc + LAT});
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    #1;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_id", 64'(done_id), 64'd0);
    issue(4'b0100, 4'b0100, "gnt_in_reset");
    req = '0;
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < NREQ; i++) set_op(i, 64'(i), 64'd10, ADD);
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      issue(req, 4'(1 << k), "contend_gnt");
      expect_res(k, 64'(10 + k), 1'b0, 1'b0);
      step();
      req[k] = 1'b0;
    end
    step();

    set_op(0, 64'd5, 64'd3, ADD);
    issue(4'b0001, 4'b0001, "single_add_gnt");
    expect_res(0, 64'd8, 1'b0, 1'b0);
    step();
    req = '0;
    step();

    set_op(2, 64'd7, 64'd7, ADD);
    issue(4'b0100, 4'b0100, "rr_gnt2");
    expect_res(2, 64'd14, 1'b0, 1'b0);
    step();
    set_op(3, 64'd1, 64'd2, ADD);
    set_op(0, 64'd100, 64'd200, ADD);
    issue(4'b1001, 4'b1000, "rr_gnt3");
    expect_res(3, 64'd3, 1'b0, 1'b0);
    step();
    issue(4'b0001, 4'b0001, "rr_gnt0");
    expect_res(0, 64'd300, 1'b0, 1'b0);
    step();

    set_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, CMP);
    set_op(2, 64'h8000_0000_0000_0000, 64'd1, SUB);
    issue(4'b0110, 4'b0010, "rr_ptr1_cmp_gnt");
    expect_res(1, 64'd1, 1'b0, 1'b0);
    step();
    issue(4'b0100, 4'b0100, "sub_ovf_gnt");
    expect_res(2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    step();
    req = '0;
    step();

    for (int k = 0; k < 3; k++) begin
      set_op(0, 64'(20 + k), 64'd1, ADD);
      issue(4'b0001, 4'b0001, "b2b_gnt");
      expect_res(0, 64'(21 + k), 1'b0, 1'b0);
      step();
    end
    req = '0;
    step();
    step();

    set_op(1, 64'd40, 64'd2, ADD);
    issue(4'b0010, 4'b0010, "flight_gnt");
    step();
    req = '0;
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    chk("no_done_after_rst", 64'(done), 64'd0);
    chk("done_id_after_rst", 64'(done_id), 64'd0);
    set_op(1, 64'd9, 64'd9, ADD);
    set_op(3, 64'd1, 64'd1, ADD);
    issue(4'b1010, 4'b0010, "ptr_reset_gnt");
    expect_res(1, 64'd18, 1'b0, 1'b0);
    step();
    issue(4'b1000, 4'b1000, "after_rst_gnt3");
    expect_res(3, 64'd2, 1'b0, 1'b0);
    step();
    req = '0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    step();
    chk("drain_pending", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
